nabp_swap_control: RTL and testbench

Angle dispenser and shift arbiter for a pair of NABP state-control units. It hands out successive projection angles to whichever unit requests one, tracks each unit's fill/shift progress, and issues the one-cycle swap pulse that moves a filled unit into its shift phase. Only one unit may shift at any time. The block sits above the two state-control/shifter pairs and drives their angle and swap inputs.

---
 rtl/nabp_swap_control.sv | 250 +++++++++++++++++++++++++
 tb/tb_nabp_swap_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/nabp_swap_control.sv
// -----------------------------------------------------------------------------
// nabp_swap_control
//
// Angle dispenser and shift arbiter for a pair of NABP state-control units.
// Successive projection angles are handed to whichever unit asks for one. Each
// unit's fill/shift progress is tracked, and a one-cycle swap pulse moves a
// filled unit into its shift phase. At most one unit shifts at any time.
//
// Parameters
//   ANGLE_WIDTH  width of angle values
//   ANGLE_START  first angle issued
//   ANGLE_END    last legal angle, inclusive
//   ANGLE_STEP   angle increment (>= 1)
//
// Ports
//   clk                     clock
//   reset_n                 synchronous, active-low reset
//   sc0/1_next_angle        angle request from unit 0 / 1
//   sc0/1_fill_done         one-cycle pulse: unit's shifter finished filling
//   sc0/1_shift_done        one-cycle pulse: unit's shifter finished shifting
//   sc0/1_angle             angle offered to the unit (registered)
//   sc0/1_angle_valid       offered angle is real; 0 means the unit is parked
//   sc0/1_swap              one-cycle swap pulse (registered)
//   all_done                sticky: all angles issued and both units parked
//   proto_err               sticky: an input arrived that is illegal for the
//                           tracked unit state
// -----------------------------------------------------------------------------
module nabp_swap_control #(
    parameter int ANGLE_WIDTH = 8,
    parameter int ANGLE_START = 0,
    parameter int ANGLE_END   = 179,
    parameter int ANGLE_STEP  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sc0_next_angle,
    input  logic                   sc1_next_angle,
    input  logic                   sc0_fill_done,
    input  logic                   sc1_fill_done,
    input  logic                   sc0_shift_done,
    input  logic                   sc1_shift_done,
    output logic [ANGLE_WIDTH-1:0] sc0_angle,
    output logic [ANGLE_WIDTH-1:0] sc1_angle,
    output logic                   sc0_angle_valid,
    output logic                   sc1_angle_valid,
    output logic                   sc0_swap,
    output logic                   sc1_swap,
    output logic                   all_done,
    output logic                   proto_err
);

    // One extra bit so the counter can sit just past ANGLE_END without wrapping.
    localparam int CW = ANGLE_WIDTH + 1;
    localparam logic [CW-1:0] CNT_START = CW'(ANGLE_START);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(ANGLE_END + 1);
    localparam logic [CW-1:0] CNT_STEP  = CW'(ANGLE_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FILLED,
        S_SHIFT,
        S_PARKED
    } trk_e;

    // Add with saturation at ANGLE_END+1: once exhausted, the counter stays
    // at the first "no angle available" value.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, CNT_LIMIT}) begin
            sat_add = CNT_LIMIT;
        end else begin
            sat_add = s[CW-1:0];
        end
    endfunction

    trk_e                   st0_q, st0_d, st1_q, st1_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   order_q, order_d;     // unit holding the earlier angle
    logic                   sdone0_q, sdone0_d;   // shift_done seen while in SHIFT
    logic                   sdone1_q, sdone1_d;
    logic [ANGLE_WIDTH-1:0] ang0_q, ang0_d, ang1_q, ang1_d;
    logic                   vld0_q, vld0_d, vld1_q, vld1_d;
    logic                   swap0_q, swap0_d, swap1_q, swap1_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // Combinational helpers
    logic          req0, req1;
    logic [CW-1:0] cnt_p1;
    logic          avail0, avail1;
    logic          busy0, busy1, grant_ok, filled0, filled1;
    logic          err_now;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st0_q    <= S_IDLE;
            st1_q    <= S_IDLE;
            cnt_q    <= CNT_START;
            order_q  <= 1'b0;
            sdone0_q <= 1'b0;
            sdone1_q <= 1'b0;
            ang0_q   <= '0;
            ang1_q   <= '0;
            vld0_q   <= 1'b0;
            vld1_q   <= 1'b0;
            swap0_q  <= 1'b0;
            swap1_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st0_q    <= st0_d;
            st1_q    <= st1_d;
            cnt_q    <= cnt_d;
            order_q  <= order_d;
            sdone0_q <= sdone0_d;
            sdone1_q <= sdone1_d;
            ang0_q   <= ang0_d;
            ang1_q   <= ang1_d;
            vld0_q   <= vld0_d;
            vld1_q   <= vld1_d;
            swap0_q  <= swap0_d;
            swap1_q  <= swap1_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        st0_d    = st0_q;
        st1_d    = st1_q;
        cnt_d    = cnt_q;
        order_d  = order_q;
        sdone0_d = sdone0_q;
        sdone1_d = sdone1_q;
        ang0_d   = ang0_q;
        ang1_d   = ang1_q;
        vld0_d   = vld0_q;
        vld1_d   = vld1_q;
        swap0_d  = 1'b0;
        swap1_d  = 1'b0;
        err_now  = 1'b0;

        // Only requests from IDLE/SHIFT consume angles; PARKED ignores them.
        req0   = sc0_next_angle && (st0_q == S_IDLE || st0_q == S_SHIFT);
        req1   = sc1_next_angle && (st1_q == S_IDLE || st1_q == S_SHIFT);
        cnt_p1 = sat_add(cnt_q, CNT_STEP);
        avail0 = (cnt_q < CNT_LIMIT);
        avail1 = (cnt_p1 < CNT_LIMIT);

        if (sc0_next_angle && (st0_q == S_FILL || st0_q == S_FILLED)) err_now = 1'b1;
        if (sc1_next_angle && (st1_q == S_FILL || st1_q == S_FILLED)) err_now = 1'b1;

        // Angle issue. On simultaneous requests unit 0 takes the lower angle.
        if (req0 && req1) begin
            if (avail0) begin
                st0_d  = S_FILL;
                ang0_d = cnt_q[ANGLE_WIDTH-1:0];
                vld0_d = 1'b1;
            end else begin
                st0_d  = S_PARKED;
                vld0_d = 1'b0;
            end
            if (avail1) begin
                st1_d  = S_FILL;
                ang1_d = cnt_p1[ANGLE_WIDTH-1:0];
                vld1_d = 1'b1;
            end else begin
                st1_d  = S_PARKED;
                vld1_d = 1'b0;
            end
            cnt_d   = sat_add(cnt_p1, CNT_STEP);
            order_d = 1'b0;
        end else if (req0) begin
            if (avail0) begin
                st0_d   = S_FILL;
                ang0_d  = cnt_q[ANGLE_WIDTH-1:0];
                vld0_d  = 1'b1;
                order_d = 1'b1;
            end else begin
                st0_d  = S_PARKED;
                vld0_d = 1'b0;
            end
            cnt_d = cnt_p1;
        end else if (req1) begin
            if (avail0) begin
                st1_d   = S_FILL;
                ang1_d  = cnt_q[ANGLE_WIDTH-1:0];
                vld1_d  = 1'b1;
                order_d = 1'b0;
            end else begin
                st1_d  = S_PARKED;
                vld1_d = 1'b0;
            end
            cnt_d = cnt_p1;
        end

        if (sc0_fill_done) begin
            if (st0_q == S_FILL) st0_d = S_FILLED;
            else                 err_now = 1'b1;
        end
        if (sc1_fill_done) begin
            if (st1_q == S_FILL) st1_d = S_FILLED;
            else                 err_now = 1'b1;
        end

        // A unit that reported shift_done still sits in SHIFT until its next
        // request, but it no longer blocks the other unit from shifting.
        if (sc0_shift_done) begin
            if (st0_q == S_SHIFT) sdone0_d = 1'b1;
            else                  err_now = 1'b1;
        end
        if (sc1_shift_done) begin
            if (st1_q == S_SHIFT) sdone1_d = 1'b1;
            else                  err_now = 1'b1;
        end

        // Shift arbitration
        busy0    = (st0_q == S_SHIFT) && !sdone0_q;
        busy1    = (st1_q == S_SHIFT) && !sdone1_q;
        filled0  = (st0_q == S_FILLED);
        filled1  = (st1_q == S_FILLED);
        grant_ok = !busy0 && !busy1 && !swap0_q && !swap1_q;
        if (grant_ok && filled0 && (!filled1 || !order_q)) begin
            st0_d   = S_SHIFT;
            swap0_d = 1'b1;
        end else if (grant_ok && filled1) begin
            st1_d   = S_SHIFT;
            swap1_d = 1'b1;
        end

        if (st0_d != S_SHIFT) sdone0_d = 1'b0;
        if (st1_d != S_SHIFT) sdone1_d = 1'b0;

        err_d  = err_q | err_now;
        done_d = done_q | ((st0_q == S_PARKED) && (st1_q == S_PARKED));
    end

    assign sc0_angle       = ang0_q;
    assign sc1_angle       = ang1_q;
    assign sc0_angle_valid = vld0_q;
    assign sc1_angle_valid = vld1_q;
    assign sc0_swap        = swap0_q;
    assign sc1_swap        = swap1_q;
    assign all_done        = done_q;
    assign proto_err       = err_q;

endmodule

// File: tb/tb_nabp_swap_control.sv
module tb_nabp_swap_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- main DUT (default parameters) ----
    logic       rst_n, na0, na1, fd0, fd1, sd0, sd1;
    logic [7:0] a0, a1;
    logic       v0, v1, sw0, sw1, ad, pe;

    nabp_swap_control dut (
        .clk(clk), .reset_n(rst_n),
        .sc0_next_angle(na0), .sc1_next_angle(na1),
        .sc0_fill_done(fd0), .sc1_fill_done(fd1),
        .sc0_shift_done(sd0), .sc1_shift_done(sd1),
        .sc0_angle(a0), .sc1_angle(a1),
        .sc0_angle_valid(v0), .sc1_angle_valid(v1),
        .sc0_swap(sw0), .sc1_swap(sw1),
        .all_done(ad), .proto_err(pe)
    );

    // ---- small DUT (ANGLE_END = 2) ----
    logic       s_rst_n, s_na0, s_na1, s_fd0, s_fd1, s_sd0, s_sd1;
    logic [7:0] s_a0, s_a1;
    logic       s_v0, s_v1, s_sw0, s_sw1, s_ad, s_pe;

    nabp_swap_control #(.ANGLE_WIDTH(8), .ANGLE_START(0), .ANGLE_END(2), .ANGLE_STEP(1)) dut_s (
        .clk(clk), .reset_n(s_rst_n),
        .sc0_next_angle(s_na0), .sc1_next_angle(s_na1),
        .sc0_fill_done(s_fd0), .sc1_fill_done(s_fd1),
        .sc0_shift_done(s_sd0), .sc1_shift_done(s_sd1),
        .sc0_angle(s_a0), .sc1_angle(s_a1),
        .sc0_angle_valid(s_v0), .sc1_angle_valid(s_v1),
        .sc0_swap(s_sw0), .sc1_swap(s_sw1),
        .all_done(s_ad), .proto_err(s_pe)
    );

    typedef struct {
        string      name;
        logic [6:0] in;    // {rst_n, na0, na1, fd0, fd1, sd0, sd1}
        logic [7:0] ea0;
        logic [7:0] ea1;
        logic [5:0] eflg;  // {v0, v1, sw0, sw1, all_done, proto_err}
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(string name, logic [6:0] in, int ea0, int ea1, logic [5:0] eflg);
        vec_t v;
        v.name = name; v.in = in; v.ea0 = 8'(ea0); v.ea1 = 8'(ea1); v.eflg = eflg;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step_main(logic [6:0] in);
        @(negedge clk);
        {rst_n, na0, na1, fd0, fd1, sd0, sd1} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic step_s(logic r, logic n0, logic n1, logic f0, logic f1, logic d0, logic d1);
        @(negedge clk);
        s_rst_n = r; s_na0 = n0; s_na1 = n1; s_fd0 = f0; s_fd1 = f1; s_sd0 = d0; s_sd1 = d1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] s_flags();
        return {18'd0, s_a0, s_v0, s_v1, s_sw0, s_sw1, s_ad, s_pe};
    endfunction

    initial begin
        {rst_n, na0, na1, fd0, fd1, sd0, sd1} = 7'b0;
        {s_rst_n, s_na0, s_na1, s_fd0, s_fd1, s_sd0, s_sd1} = 7'b0;

        //    name            rst na0 na1 fd0 fd1 sd0 sd1    a0 a1   v0 v1 sw0 sw1 ad pe
        add("reset",          7'b0_0_0_0_0_0_0, 0, 0, 6'b00_00_0_0);
        add("both_req",       7'b1_1_1_0_0_0_0, 0, 1, 6'b11_00_0_0);
        add("hold1",          7'b1_0_0_0_0_0_0, 0, 1, 6'b11_00_0_0);
        add("hold2",          7'b1_0_0_0_0_0_0, 0, 1, 6'b11_00_0_0);
        add("fill0",          7'b1_0_0_1_0_0_0, 0, 1, 6'b11_00_0_0);
        add("swap0",          7'b1_0_0_0_0_0_0, 0, 1, 6'b11_10_0_0);
        add("swap0_end",      7'b1_0_0_0_1_0_0, 0, 1, 6'b11_00_0_0);
        add("blk1",           7'b1_0_0_0_0_0_0, 0, 1, 6'b11_00_0_0);
        add("sdone0",         7'b1_0_0_0_0_1_0, 0, 1, 6'b11_00_0_0);
        add("req0_swap1",     7'b1_1_0_0_0_0_0, 2, 1, 6'b11_01_0_0);
        add("swap1_end",      7'b1_0_0_0_0_0_0, 2, 1, 6'b11_00_0_0);
        add("fill0_b",        7'b1_0_0_1_0_0_0, 2, 1, 6'b11_00_0_0);
        add("blk0",           7'b1_0_0_0_0_0_0, 2, 1, 6'b11_00_0_0);
        add("sdone1",         7'b1_0_0_0_0_0_1, 2, 1, 6'b11_00_0_0);
        add("req1_swap0",     7'b1_0_1_0_0_0_0, 2, 3, 6'b11_10_0_0);
        add("swap0_end_b",    7'b1_0_0_0_0_0_0, 2, 3, 6'b11_00_0_0);
        add("sdone0_b",       7'b1_0_0_0_0_1_0, 2, 3, 6'b11_00_0_0);
        add("req0_late",      7'b1_1_0_0_0_0_0, 4, 3, 6'b11_00_0_0);
        add("fill_both",      7'b1_0_0_1_1_0_0, 4, 3, 6'b11_00_0_0);
        add("order_swap1",    7'b1_0_0_0_0_0_0, 4, 3, 6'b11_01_0_0);
        add("order_wait1",    7'b1_0_0_0_0_0_0, 4, 3, 6'b11_00_0_0);
        add("order_wait2",    7'b1_0_0_0_0_0_0, 4, 3, 6'b11_00_0_0);
        add("order_sdone1",   7'b1_0_0_0_0_0_1, 4, 3, 6'b11_00_0_0);
        add("order_swap0",    7'b1_0_0_0_0_0_0, 4, 3, 6'b11_10_0_0);
        add("order_end",      7'b1_0_0_0_0_0_0, 4, 3, 6'b11_00_0_0);
        add("req1_5",         7'b1_0_1_0_0_0_0, 4, 5, 6'b11_00_0_0);
        add("err_sd_fill",    7'b1_0_0_0_0_0_1, 4, 5, 6'b11_00_0_1);
        add("err_sticky",     7'b1_0_0_0_0_0_0, 4, 5, 6'b11_00_0_1);
        add("fill1_after",    7'b1_0_0_0_1_0_0, 4, 5, 6'b11_00_0_1);
        add("sdone0_c",       7'b1_0_0_0_0_1_0, 4, 5, 6'b11_00_0_1);
        add("swap1_intact",   7'b1_0_0_0_0_0_0, 4, 5, 6'b11_01_0_1);
        add("mid_reset",      7'b0_0_0_0_0_0_0, 0, 0, 6'b00_00_0_0);
        add("post_rst_req0",  7'b1_1_0_0_0_0_0, 0, 0, 6'b10_00_0_0);
        add("post_rst_req1",  7'b1_0_1_0_0_0_0, 0, 1, 6'b11_00_0_0);
        add("err_req_fill",   7'b1_1_0_0_0_0_0, 0, 1, 6'b11_00_0_1);

        foreach (vecs[i]) begin
            step_main(vecs[i].in);
            check(vecs[i].name, {8'd0, a0, a1, 2'b00, v0, v1, sw0, sw1, ad, pe},
                  {8'd0, vecs[i].ea0, vecs[i].ea1, 2'b00, vecs[i].eflg});
        end

        // Full run with ANGLE_END=2: angles 0,1,2 once each, then parking.
        // Flags below are {a0, v0, v1, sw0, sw1, all_done, proto_err}.
        step_s(0, 0, 0, 0, 0, 0, 0);
        check("s_reset", s_flags(), {18'd0, 8'd0, 6'b00_00_0_0});
        step_s(1, 1, 1, 0, 0, 0, 0);
        check("s_req_both_a1", {24'd0, s_a1}, 32'd1);
        check("s_req_both", s_flags(), {18'd0, 8'd0, 6'b11_00_0_0});
        step_s(1, 0, 0, 1, 1, 0, 0);
        step_s(1, 0, 0, 0, 0, 0, 0);
        check("s_swap0", s_flags(), {18'd0, 8'd0, 6'b11_10_0_0});
        step_s(1, 0, 0, 0, 0, 0, 0);
        step_s(1, 0, 0, 0, 0, 1, 0);
        step_s(1, 1, 0, 0, 0, 0, 0);
        check("s_angle2_swap1", s_flags(), {18'd0, 8'd2, 6'b11_01_0_0});
        step_s(1, 0, 0, 1, 0, 0, 0);
        step_s(1, 0, 0, 0, 0, 0, 1);
        step_s(1, 0, 1, 0, 0, 0, 0);
        check("s_park1_a1", {24'd0, s_a1}, 32'd1);
        check("s_park1", s_flags(), {18'd0, 8'd2, 6'b10_10_0_0});
        step_s(1, 0, 0, 0, 0, 0, 0);
        step_s(1, 0, 0, 0, 0, 1, 0);
        step_s(1, 1, 0, 0, 0, 0, 0);
        check("s_park0", s_flags(), {18'd0, 8'd2, 6'b00_00_0_0});
        step_s(1, 0, 0, 0, 0, 0, 0);
        check("s_all_done", s_flags(), {18'd0, 8'd2, 6'b00_00_1_0});
        step_s(1, 1, 1, 0, 0, 0, 0);
        check("s_parked_ignore", s_flags(), {18'd0, 8'd2, 6'b00_00_1_0});
        step_s(0, 0, 0, 0, 0, 0, 0);
        check("s_reset_clears", s_flags(), {18'd0, 8'd0, 6'b00_00_0_0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
